event_monitor: RTL and testbench
================================

# event_monitor

Downstream consumer of the registered OR-combined event line produced by the set/reset stage. It watches that 1-bit level and detects rising edges. For each edge it drives a retriggerable stretched pulse for slow observers and counts events in a saturating counter. A read-to-clear valid/ack handshake lets a control agent snapshot the count and overflow status.

## Interface
- COUNT_W, 8, width of event counter and snapshot data (≥2)
- HOLD_CYCLES, 4, length in cycles of stretched pulse (≥1)
- i_clk  input  1  clock
- i_arst  input  1  reset i_arst, asynchronous, active-low; clock i_clk
- i_evt  input  1  event level from upstream register stage
- i_rdReq  input  1  snapshot request, sampled in RD_IDLE only
- i_rdAck  input  1  snapshot consumed, sampled in RD_PEND only
- o_evtStretch  output  1  high for HOLD_CYCLES cycles after the latest recognised edge
- o_count  output  COUNT_W  live event count
- o_rdVld  output  1  snapshot valid
- o_rdDat  output  COUNT_W  snapshot count
- o_rdOvf  output  1  snapshot overflow flag

## Operation
- Edge recognition: evt_q registers i_evt. edge = i_evt && !evt_q. Without the filter, i_evt high continuously is one event.
- Counter: on edge, count increments. At 2^COUNT_W−1 it holds and sets sticky ovf.
- Stretch: on edge, hold counter loads HOLD_CYCLES. It decrements to 0 otherwise. o_evtStretch = (hold counter != 0). An edge while stretching reloads the counter (retrigger).
- Readout FSM states: RD_IDLE, RD_PEND.
  - RD_IDLE & i_rdReq: o_rdDat ← count_next (includes an edge in the same cycle), o_rdOvf ← ovf_next. Count and ovf clear to 0. Next state RD_PEND.
  - RD_PEND: o_rdVld=1. o_rdDat and o_rdOvf are held stable. i_rdReq is ignored. Counting continues into the cleared counter.
  - RD_PEND & i_rdAck: next state RD_IDLE. A request is accepted no earlier than the following cycle.
  - i_rdAck in RD_IDLE is ignored.
- Reset: o_evtStretch=0, o_count=0, o_rdVld=0, o_rdDat=0, o_rdOvf=0, evt_q=0, FSM=RD_IDLE. Assertion mid-stretch or mid-handshake aborts immediately.
- i_evt high on the first clock after reset release counts as an edge.

## Timing
- Edge sampled at clock edge N: o_count and o_evtStretch update after edge N (1-cycle latency from i_evt).
- o_evtStretch is high for exactly HOLD_CYCLES cycles after an isolated edge.
- i_rdReq accepted at edge N: o_rdVld, o_rdDat and o_rdOvf are valid after edge N. o_count reads 0 (or 1 if an edge occurs at N+1) from N+1.
- Minimum handshake period is 2 cycles.
- Saturation: count_next = count when count is at max. ovf is set in the same cycle.

## Configuration
- EVENT_MONITOR_GLITCH_FILTER_EN defined: i_evt passes through a 2-stage register. The filtered level rises only when i_evt has been high for 2 consecutive samples. A 1-cycle high glitch is discarded. Edge-to-output latency becomes 3 cycles.
- Not defined: raw 1-cycle path as above. A 1-cycle high pulse counts.

## Structure
- Package event_monitor_pkg holds:
  - the rd_state_t enum (RD_IDLE, RD_PEND);
  - function holdWidth(HOLD_CYCLES) = $clog2(HOLD_CYCLES+1);
  - COUNT_W_MIN = 2.
- One sub-module, event_stretcher, contains edge detect, the optional filter and the hold counter, and outputs edge and o_evtStretch. Counter and readout FSM stay in the top module.

## Test plan
- Reset released with i_evt=0; three isolated 1-cycle pulses -> o_count=3; each o_evtStretch high exactly 4 cycles.
- Pulses 2 cycles apart, HOLD_CYCLES=4 -> o_evtStretch continuously high until 4 cycles after the last edge.
- COUNT_W=2, 5 edges -> o_count=3. Then i_rdReq -> o_rdDat=3, o_rdOvf=1, o_count=0.
- i_rdReq coincident with the 4th edge (count was 3) -> o_rdDat=4, o_count=0. A further edge in RD_PEND -> o_count=1; o_rdDat stays 4 until i_rdAck.
- i_rdReq held high through RD_PEND and ack -> second snapshot captured one cycle after ack, o_rdVld low for exactly 1 cycle.
- EVENT_MONITOR_GLITCH_FILTER_EN: 1-cycle glitch -> o_count=0. A 2-cycle pulse -> o_count=1, o_evtStretch rises 3 cycles after i_evt. Reset asserted mid-handshake -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/event_monitor_pkg.sv
// Shared types and helpers for the event monitor: readout FSM states and
// the hold-counter width calculation.
package event_monitor_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } rd_state_t;

  localparam int COUNT_W_MIN = 2;

  // Bits needed to hold the values 0..hold_cycles in the stretch counter.
  function automatic int holdWidth(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/event_stretcher.sv
// Rising-edge detector with retriggerable pulse stretcher. Defining
// EVENT_MONITOR_GLITCH_FILTER_EN inserts a 2-sample filter in front of the detector.
module event_stretcher
  import event_monitor_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic evt_i,
  output logic edge_o,
  output logic stretch_o
);

  localparam int HW = holdWidth(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  logic          lvl;
  logic          evt_q;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;

`ifdef EVENT_MONITOR_GLITCH_FILTER_EN
  logic samp1_q;
  logic samp2_q;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      samp1_q <= 1'b0;
      samp2_q <= 1'b0;
    end else begin
      samp1_q <= evt_i;
      samp2_q <= samp1_q;
    end
  end

  // Level only rises after two consecutive high samples, so 1-cycle glitches vanish.
  assign lvl = samp1_q & samp2_q;
`else
  assign lvl = evt_i;
`endif

  assign edge_o    = lvl & ~evt_q;
  assign stretch_o = (hold_q != '0);

  always_comb begin
    hold_d = hold_q;
    if (edge_o) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      evt_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      evt_q  <= lvl;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/event_monitor.sv
// Event monitor: counts rising edges of i_evt with saturation, stretches them,
// and offers a read-to-clear snapshot. Optional macro: EVENT_MONITOR_GLITCH_FILTER_EN.
//
// Handshake: a request is taken only in RD_IDLE; o_rdVld then stays high with
// o_rdDat/o_rdOvf frozen until i_rdAck is seen, and the next request is taken
// no earlier than the cycle after the ack.
module event_monitor
  import event_monitor_pkg::*;
#(
  parameter int COUNT_W     = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic               i_evt,
  input  logic               i_rdReq,
  input  logic               i_rdAck,
  output logic               o_evtStretch,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_rdVld,
  output logic [COUNT_W-1:0] o_rdDat,
  output logic               o_rdOvf,
  output logic               o_rdState
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  rd_state_t          state_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic [COUNT_W-1:0] rd_dat_q;
  logic               ovf_q;
  logic               ovf_d;
  logic               rd_vld_q;
  logic               rd_ovf_q;
  logic               evt_edge;

  event_stretcher #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretcher (
    .i_clk    (i_clk),
    .i_arst   (i_arst),
    .evt_i    (i_evt),
    .edge_o   (evt_edge),
    .stretch_o(o_evtStretch)
  );

  // Next count includes an edge in the current cycle, so a snapshot taken
  // on the same clock still sees it.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (evt_edge) begin
      if (count_q == COUNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q  <= RD_IDLE;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
      rd_ovf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      case (state_q)
        RD_IDLE: begin
          if (i_rdReq) begin
            rd_dat_q <= count_d;
            rd_ovf_q <= ovf_d;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rd_vld_q <= 1'b1;
            state_q  <= RD_PEND;
          end
        end
        RD_PEND: begin
          if (i_rdAck) begin
            rd_vld_q <= 1'b0;
            state_q  <= RD_IDLE;
          end
        end
        default: begin
          rd_vld_q <= 1'b0;
          state_q  <= RD_IDLE;
        end
      endcase
    end
  end

  assign o_count   = count_q;
  assign o_rdVld   = rd_vld_q;
  assign o_rdDat   = rd_dat_q;
  assign o_rdOvf   = rd_ovf_q;
  assign o_rdState = state_q;

endmodule

// File: tb/tb_event_monitor.sv
// Bench for event_monitor: directed scenarios plus random traffic against an
// edge/count/snapshot reference model, with a snapshot scoreboard.
module tb_event_monitor;

  localparam int CW   = 3;
  localparam int HOLD = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef EVENT_MONITOR_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          i_clk;
  logic          i_arst;
  logic          i_evt;
  logic          i_rdReq;
  logic          i_rdAck;
  logic          o_evtStretch;
  logic [CW-1:0] o_count;
  logic          o_rdVld;
  logic [CW-1:0] o_rdDat;
  logic          o_rdOvf;
  logic          o_rdState;

  event_monitor #(
    .COUNT_W    (CW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_evt       (i_evt),
    .i_rdReq     (i_rdReq),
    .i_rdAck     (i_rdAck),
    .o_evtStretch(o_evtStretch),
    .o_count     (o_count),
    .o_rdVld     (o_rdVld),
    .o_rdDat     (o_rdDat),
    .o_rdOvf     (o_rdOvf),
    .o_rdState   (o_rdState)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: {ovf, count} per accepted snapshot
  logic [CW:0] exp_q[$];

  // reference model state
  int m_count;
  bit m_ovf;
  bit m_pend;
  bit m_lvl_prev;
  bit m_hist1;
  bit m_hist2;
  int m_last_edge;
  int m_cyc;
  bit exp_stretch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_count     = 0;
    m_ovf       = 1'b0;
    m_pend      = 1'b0;
    m_lvl_prev  = 1'b0;
    m_hist1     = 1'b0;
    m_hist2     = 1'b0;
    m_last_edge = -1000;
    exp_stretch = 1'b0;
    exp_q.delete();
  endtask

  // driver: apply inputs for one clock, advance the model, check after the edge
  task automatic cycle(input logic e, input logic r, input logic a);
    bit lvl;
    bit edge_seen;
    i_evt   = e;
    i_rdReq = r;
    i_rdAck = a;
    lvl        = FILT ? (m_hist1 && m_hist2) : e;
    edge_seen  = lvl && !m_lvl_prev;
    m_lvl_prev = lvl;
    m_hist2    = m_hist1;
    m_hist1    = e;
    if (edge_seen) begin
      m_last_edge = m_cyc;
      if (m_count == MAXC) m_ovf = 1'b1;
      else m_count = m_count + 1;
    end
    exp_stretch = (m_cyc - m_last_edge) < HOLD;
    if (!m_pend && r) begin
      exp_q.push_back({m_ovf, CW'(m_count)});
      m_count = 0;
      m_ovf   = 1'b0;
      m_pend  = 1'b1;
    end else if (m_pend && a) begin
      m_pend = 1'b0;
    end
    m_cyc++;
    @(posedge i_clk);
    @(negedge i_clk);
    check("count", o_count, m_count);
    check("stretch", o_evtStretch, exp_stretch);
    check("rd_vld", o_rdVld, m_pend);
    check("rd_state", o_rdState, m_pend);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // monitor: pops a snapshot on each o_rdVld rise, checks it stays frozen
  logic        vld_prev = 1'b0;
  logic [CW:0] snap_exp = '0;
  always @(negedge i_clk) begin
    if (o_rdVld && !vld_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL snap_unexpected: got dat=%0d ovf=%0d required no snapshot", o_rdDat, o_rdOvf);
      end else begin
        snap_exp = exp_q.pop_front();
        check("snap_dat", o_rdDat, snap_exp[CW-1:0]);
        check("snap_ovf", o_rdOvf, snap_exp[CW]);
      end
    end else if (o_rdVld) begin
      check("snap_hold", {o_rdOvf, o_rdDat}, snap_exp);
    end
    vld_prev = o_rdVld;
  end

  initial begin
    i_arst  = 1'b0;
    i_evt   = 1'b0;
    i_rdReq = 1'b0;
    i_rdAck = 1'b0;
    m_cyc   = 0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check("rst_count", o_count, 0);
    check("rst_stretch", o_evtStretch, 0);
    check("rst_vld", o_rdVld, 0);
    check("rst_dat", o_rdDat, 0);
    check("rst_ovf", o_rdOvf, 0);
    check("rst_state", o_rdState, 0);
    i_arst = 1'b1;

    // three isolated pulses
    for (int p = 0; p < 3; p++) begin
      cycle(1'b1, 1'b0, 1'b0);
      idle(5);
    end
    check("three_pulses", o_count, 3);

    // pulses two cycles apart keep the stretch continuous
    for (int p = 0; p < 3; p++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    idle(5);

    // drive into saturation, then read and clear
    for (int p = 0; p < 3; p++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("saturated", o_count, MAXC);
    cycle(1'b0, 1'b1, 1'b0);
    check("sat_snap_dat", o_rdDat, MAXC);
    check("sat_snap_ovf", o_rdOvf, 1);
    check("sat_cleared", o_count, 0);
    cycle(1'b0, 1'b0, 1'b1);

    // request coincident with the 4th edge, then an edge while pending
    for (int p = 0; p < 3; p++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    idle(2);
    check("pend_dat", o_rdDat, FILT ? 3 : 4);
    check("pend_count", o_count, 1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // request held through pending and ack: re-accepted one cycle later
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // 1-cycle glitch and 2-cycle pulse
    cycle(1'b1, 1'b0, 1'b0);
    idle(6);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle(6);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30);
    end

    // reset mid-handshake and mid-stretch
    if (m_pend) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    #2 i_arst = 1'b0;
    #1;
    check("arst_count", o_count, 0);
    check("arst_stretch", o_evtStretch, 0);
    check("arst_vld", o_rdVld, 0);
    check("arst_dat", o_rdDat, 0);
    check("arst_ovf", o_rdOvf, 0);
    @(negedge i_clk);
    model_reset();
    i_arst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    idle(6);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
